// File: rtl/l0mdt_pkg.sv
// Shared l0mdt types for the MTC builder.
// Holds the bus payload structs (pT-calc result, SL pipeline candidate,
// MTC packet), the per-thread slot struct, the procflag codes and the
// helpers used to classify a matched result and to saturate statistics.
package l0mdt_pkg;

    localparam int unsigned SLID_W = 2;
    localparam int unsigned PT_W   = 9;
    localparam int unsigned PTTH_W = 4;
    localparam int unsigned ETA_W  = 8;
    localparam int unsigned PHI_W  = 6;
    localparam int unsigned NSEG_W = 2;
    localparam int unsigned COIN_W = 3;
    localparam int unsigned CH_W   = 4;
    localparam int unsigned PF_W   = 4;
    localparam int unsigned RSV_W  = 3;
    localparam int unsigned CNT_W  = 16;

    localparam logic [PF_W-1:0] PF_PASS    = 4'h1;
    localparam logic [PF_W-1:0] PF_FAIL    = 4'h2;
    localparam logic [PF_W-1:0] PF_BOARD   = 4'h3;
    localparam logic [PF_W-1:0] PF_NOSEG   = 4'h4;
    localparam logic [PF_W-1:0] PF_ONESEG  = 4'h5;
    localparam logic [PF_W-1:0] PF_PTFAIL  = 4'h6;
    localparam logic [PF_W-1:0] PF_MISSING = 4'hE;
    localparam logic [PF_W-1:0] PF_UNKNOWN = 4'hF;

    // pT-calc result; valid is the MSB
    typedef struct packed {
        logic              valid;
        logic [SLID_W-1:0] muid_slid;
        logic [PT_W-1:0]   pt;
        logic [PTTH_W-1:0] ptthresh;
        logic [ETA_W-1:0]  eta;
        logic [NSEG_W-1:0] nseg;
        logic              charge;
    } ptcalc2mtc_t;

    // SL trigger fields copied straight into the MTC packet
    typedef struct packed {
        logic [COIN_W-1:0] cointype;
        logic [PTTH_W-1:0] ptthresh;
        logic [ETA_W-1:0]  eta;
        logic [PHI_W-1:0]  phi;
        logic              charge;
    } sl_common_t;

    typedef struct packed {
        logic            data_valid;
        logic            busy;
        logic [CH_W-1:0] process_ch;
        sl_common_t      common;
    } pl2mtc_t;

    // MTC packet; valid is the MSB
    typedef struct packed {
        logic              valid;
        sl_common_t        common;
        logic [PT_W-1:0]   mdt_pt;
        logic [PTTH_W-1:0] mdt_ptthresh;
        logic [ETA_W-1:0]  mdt_eta;
        logic [NSEG_W-1:0] mdt_nseg;
        logic              mdt_charge;
        logic [PF_W-1:0]   procflags;
        logic [RSV_W-1:0]  reserved;
    } mtc2sl_t;

    // Held result per thread; the age counter lives beside it because its
    // width follows the TIMEOUT parameter of the builder instance.
    typedef struct packed {
        logic        valid;
        ptcalc2mtc_t payload;
    } slot_t;

    localparam int unsigned PTCALC2MTC_LEN = $bits(ptcalc2mtc_t);
    localparam int unsigned PL2MTC_LEN     = $bits(pl2mtc_t);
    localparam int unsigned MTC2SL_LEN     = $bits(mtc2sl_t);

    // Classify a present result against the SL candidate it is matched to
    function automatic logic [PF_W-1:0] calc_procflags(
        input logic [SLID_W-1:0] muid_slid,
        input logic [PT_W-1:0]   pt,
        input logic [PTTH_W-1:0] mdt_ptthresh,
        input logic [NSEG_W-1:0] nseg,
        input logic [PTTH_W-1:0] sl_ptthresh,
        input logic [COIN_W-1:0] cointype
    );
        logic [PF_W-1:0] pf;
        pf = PF_UNKNOWN;
        if (muid_slid != '0) begin
            pf = PF_BOARD;
        end else if (pt != '0) begin
            pf = (mdt_ptthresh >= sl_ptthresh) ? PF_PASS : PF_FAIL;
        end else if (cointype == '0) begin
            if (nseg == NSEG_W'(0)) begin
                pf = PF_NOSEG;
            end else if (nseg == NSEG_W'(1)) begin
                pf = PF_ONESEG;
            end
        end else if (nseg > NSEG_W'(2)) begin
            pf = PF_PTFAIL;
        end
        return pf;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add16(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mtc_pkt_formatter.sv
// Combinational MTC packet builder for one SL lane.
// Ports:
//   lane   - SL pipeline candidate for this lane
//   result - matched pT-calc result; result.valid=0 means no result found
//   mtc_c  - formatted packet (all-zero when the lane is not valid)
module mtc_pkt_formatter
    import l0mdt_pkg::*;
(
    input  pl2mtc_t     lane,
    input  ptcalc2mtc_t result,
    output mtc2sl_t     mtc_c
);

    // busy=0 forwards the SL fields only; busy=1 adds the MDT fields or
    // flags the missing result
    always_comb begin
        mtc_c = '0;
        if (lane.data_valid) begin
            mtc_c.valid  = 1'b1;
            mtc_c.common = lane.common;
            if (lane.busy) begin
                if (!result.valid) begin
                    mtc_c.procflags = PF_MISSING;
                end else begin
                    mtc_c.mdt_pt       = result.pt;
                    mtc_c.mdt_ptthresh = result.ptthresh;
                    mtc_c.mdt_eta      = result.eta;
                    mtc_c.mdt_nseg     = result.nseg;
                    mtc_c.mdt_charge   = result.charge;
                    mtc_c.procflags    = calc_procflags(result.muid_slid, result.pt,
                                                        result.ptthresh, result.nseg,
                                                        lane.common.ptthresh,
                                                        lane.common.cointype);
                end
            end
        end
    end

endmodule

// File: rtl/mtc_builder_matched.sv
// MTC builder: holds one pT-calc result per thread, matches SL candidates
// to them by process channel and emits registered MTC packets.
// Ports:
//   clock, rst  - system clock, synchronous active-high reset
//   ptcalc      - per-thread pT result (MSB = valid)
//   slcpipeline - per-lane SL candidate
//   mtc         - packed MTC outputs, one cycle after slcpipeline
//   drop_cnt    - saturating count of discarded pT results
//   ovf_cnt     - saturating count of valid lanes that found no output
// Build option: MTC_BUILDER_STATS_EN enables drop_cnt/ovf_cnt; without it
// both are tied to zero.
module mtc_builder_matched
    import l0mdt_pkg::*;
#(
    parameter int unsigned N_THREADS = 3,
    parameter int unsigned N_SL      = 3,
    parameter int unsigned N_MTC     = 3,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                                       clock,
    input  logic                                       rst,
    input  logic [N_THREADS-1:0][PTCALC2MTC_LEN-1:0]   ptcalc,
    input  logic [N_SL-1:0][PL2MTC_LEN-1:0]            slcpipeline,
    output logic [N_MTC-1:0][MTC2SL_LEN-1:0]           mtc,
    output logic [CNT_W-1:0]                           drop_cnt,
    output logic [CNT_W-1:0]                           ovf_cnt
);

    localparam int unsigned AGE_W = $clog2(TIMEOUT);
    localparam int unsigned THR_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
    localparam int unsigned OUT_W = $clog2(N_SL + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT - 1);

    slot_t              slot_q [N_THREADS];
    logic [AGE_W-1:0]   age_q  [N_THREADS];
    ptcalc2mtc_t        pt_in  [N_THREADS];
    pl2mtc_t            lane_in[N_SL];
    ptcalc2mtc_t        lane_res[N_SL];
    mtc2sl_t            lane_pkt_c[N_SL];
    mtc2sl_t            mtc_n  [N_MTC];
    logic [N_THREADS-1:0] taken;

    // View the flat buses as structs
    always_comb begin
        for (int t = 0; t < N_THREADS; t++) pt_in[t] = ptcalc2mtc_t'(ptcalc[t]);
        for (int s = 0; s < N_SL; s++) lane_in[s] = pl2mtc_t'(slcpipeline[s]);
    end

    // Route each consuming lane to its thread; the lowest lane claims the
    // thread, a same-cycle arrival wins over the stored result (bypass)
    always_comb begin : p_route
        logic [THR_W-1:0] ch;
        ch    = '0;
        taken = '0;
        for (int s = 0; s < N_SL; s++) begin
            lane_res[s] = '0;
            if (lane_in[s].data_valid && lane_in[s].busy &&
                (32'(lane_in[s].process_ch) < N_THREADS)) begin
                ch = THR_W'(lane_in[s].process_ch);
                if (!taken[ch]) begin
                    taken[ch] = 1'b1;
                    if (pt_in[ch].valid) begin
                        lane_res[s] = pt_in[ch];
                    end else if (slot_q[ch].valid) begin
                        lane_res[s] = slot_q[ch].payload;
                    end
                end
            end
        end
    end

    for (genvar s = 0; s < N_SL; s++) begin : g_fmt
        mtc_pkt_formatter u_fmt (
            .lane   (lane_in[s]),
            .result (lane_res[s]),
            .mtc_c  (lane_pkt_c[s])
        );
    end

    // Pack valid lanes onto the outputs in ascending lane order
    always_comb begin : p_pack
        logic [OUT_W-1:0] n_out;
        n_out = '0;
        for (int m = 0; m < N_MTC; m++) mtc_n[m] = '0;
        for (int s = 0; s < N_SL; s++) begin
            if (lane_in[s].data_valid && (32'(n_out) < N_MTC)) begin
                mtc_n[n_out] = lane_pkt_c[s];
                n_out        = n_out + OUT_W'(1);
            end
        end
    end

    // Slot update: consume > new arrival (overwrite) > timeout > ageing
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int t = 0; t < N_THREADS; t++) begin
                slot_q[t] <= '0;
                age_q[t]  <= '0;
            end
            for (int m = 0; m < N_MTC; m++) mtc[m] <= '0;
        end else begin
            for (int t = 0; t < N_THREADS; t++) begin
                if (taken[t]) begin
                    slot_q[t] <= '0;
                    age_q[t]  <= '0;
                end else if (pt_in[t].valid) begin
                    slot_q[t] <= '{valid: 1'b1, payload: pt_in[t]};
                    age_q[t]  <= '0;
                end else if (slot_q[t].valid && (age_q[t] == AGE_MAX)) begin
                    slot_q[t] <= '0;
                    age_q[t]  <= '0;
                end else if (slot_q[t].valid) begin
                    age_q[t]  <= age_q[t] + AGE_W'(1);
                end
            end
            for (int m = 0; m < N_MTC; m++) mtc[m] <= mtc_n[m];
        end
    end

`ifdef MTC_BUILDER_STATS_EN
    logic [CNT_W-1:0] drop_inc;
    logic [CNT_W-1:0] ovf_inc;

    // Per-cycle discards (overwrite or timeout) and unplaced valid lanes
    always_comb begin : p_stats
        logic [CNT_W-1:0] n_valid;
        drop_inc = '0;
        ovf_inc  = '0;
        n_valid  = '0;
        for (int t = 0; t < N_THREADS; t++) begin
            if (!taken[t] && slot_q[t].valid &&
                (pt_in[t].valid || (age_q[t] == AGE_MAX))) begin
                drop_inc = drop_inc + CNT_W'(1);
            end
        end
        for (int s = 0; s < N_SL; s++) n_valid = n_valid + CNT_W'(lane_in[s].data_valid);
        if (n_valid > CNT_W'(N_MTC)) ovf_inc = n_valid - CNT_W'(N_MTC);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            drop_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            drop_cnt <= sat_add16(drop_cnt, drop_inc);
            ovf_cnt  <= sat_add16(ovf_cnt, ovf_inc);
        end
    end
`else
    assign drop_cnt = '0;
    assign ovf_cnt  = '0;
`endif

endmodule

// File: tb/tb_mtc_builder_matched.sv
// Bench for mtc_builder_matched: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of held results.
module tb_mtc_builder_matched;
    import l0mdt_pkg::*;

    localparam int unsigned N_THREADS = 3;
    localparam int unsigned N_SL      = 4;
    localparam int unsigned N_MTC     = 2;
    localparam int unsigned TIMEOUT   = 8;
`ifdef MTC_BUILDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clock = 1'b0;
    logic rst;
    logic [N_THREADS-1:0][PTCALC2MTC_LEN-1:0] ptcalc;
    logic [N_SL-1:0][PL2MTC_LEN-1:0]          slcpipeline;
    logic [N_MTC-1:0][MTC2SL_LEN-1:0]         mtc;
    logic [15:0] drop_cnt, ovf_cnt;

    always #5 clock = ~clock;

    mtc_builder_matched #(
        .N_THREADS (N_THREADS),
        .N_SL      (N_SL),
        .N_MTC     (N_MTC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .ptcalc      (ptcalc),
        .slcpipeline (slcpipeline),
        .mtc         (mtc),
        .drop_cnt    (drop_cnt),
        .ovf_cnt     (ovf_cnt)
    );

    ptcalc2mtc_t pt_s[N_THREADS];
    pl2mtc_t     ln_s[N_SL];

    // Model: each thread holds at most one result with the cycle it arrived
    bit          m_v [N_THREADS];
    ptcalc2mtc_t m_p [N_THREADS];
    int          m_ts[N_THREADS];
    int          cyc;
    int          m_drop, m_ovf;
    mtc2sl_t     exp_mtc[N_MTC];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    function automatic logic [3:0] ref_flags(input ptcalc2mtc_t r, input sl_common_t c);
        if (r.muid_slid != 0) return 4'h3;
        if (r.pt != 0) return (r.ptthresh >= c.ptthresh) ? 4'h1 : 4'h2;
        if (c.cointype == 0) begin
            if (r.nseg == 0) return 4'h4;
            if (r.nseg == 1) return 4'h5;
            return 4'hF;
        end
        if (r.nseg == 3) return 4'h6;
        return 4'hF;
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_step();
        mtc2sl_t outq[$];
        bit      tk[N_THREADS];
        mtc2sl_t p;
        ptcalc2mtc_t r;
        bit      got;
        int      ch;
        for (int t = 0; t < N_THREADS; t++) tk[t] = 0;
        if (rst) begin
            for (int t = 0; t < N_THREADS; t++) m_v[t] = 0;
            m_drop = 0;
            m_ovf  = 0;
            for (int m = 0; m < N_MTC; m++) exp_mtc[m] = '0;
        end else begin
            for (int s = 0; s < N_SL; s++) begin
                if (ln_s[s].data_valid) begin
                    p = '0;
                    p.valid  = 1'b1;
                    p.common = ln_s[s].common;
                    if (ln_s[s].busy) begin
                        ch  = int'(ln_s[s].process_ch);
                        got = 0;
                        r   = '0;
                        if (ch < N_THREADS && !tk[ch]) begin
                            tk[ch] = 1;
                            if (pt_s[ch].valid) begin r = pt_s[ch]; got = 1; end
                            else if (m_v[ch]) begin r = m_p[ch]; got = 1; end
                        end
                        if (got) begin
                            p.mdt_pt       = r.pt;
                            p.mdt_ptthresh = r.ptthresh;
                            p.mdt_eta      = r.eta;
                            p.mdt_nseg     = r.nseg;
                            p.mdt_charge   = r.charge;
                            p.procflags    = ref_flags(r, ln_s[s].common);
                        end else begin
                            p.procflags = 4'hE;
                        end
                    end
                    outq.push_back(p);
                end
            end
            for (int m = 0; m < N_MTC; m++)
                exp_mtc[m] = (m < outq.size()) ? outq[m] : '0;
            if (outq.size() > N_MTC) m_ovf = sat(m_ovf + outq.size() - N_MTC);
            for (int t = 0; t < N_THREADS; t++) begin
                if (tk[t]) begin
                    m_v[t] = 0;
                end else if (pt_s[t].valid) begin
                    if (m_v[t]) m_drop = sat(m_drop + 1);
                    m_v[t] = 1; m_p[t] = pt_s[t]; m_ts[t] = cyc;
                end else if (m_v[t] && (cyc - m_ts[t] == TIMEOUT)) begin
                    m_drop = sat(m_drop + 1);
                    m_v[t] = 0;
                end
            end
        end
        cyc++;
    endtask

    // Apply current stimulus, advance one cycle, compare every output
    task automatic step();
        for (int t = 0; t < N_THREADS; t++) ptcalc[t] = pt_s[t];
        for (int s = 0; s < N_SL; s++) slcpipeline[s] = ln_s[s];
        model_step();
        @(posedge clock);
        #1;
        for (int m = 0; m < N_MTC; m++)
            chk($sformatf("mtc[%0d] cyc %0d", m, cyc), 64'(mtc[m]), 64'(exp_mtc[m]));
        chk($sformatf("drop_cnt cyc %0d", cyc), 64'(drop_cnt), STATS ? 64'(m_drop) : 64'(0));
        chk($sformatf("ovf_cnt cyc %0d", cyc), 64'(ovf_cnt), STATS ? 64'(m_ovf) : 64'(0));
    endtask

    task automatic idle();
        for (int t = 0; t < N_THREADS; t++) pt_s[t] = '0;
        for (int s = 0; s < N_SL; s++) ln_s[s] = '0;
    endtask

    function automatic ptcalc2mtc_t mk_pt(input int slid, input int pt, input int th, input int nseg);
        ptcalc2mtc_t r;
        r = '0;
        r.valid     = 1'b1;
        r.muid_slid = SLID_W'(slid);
        r.pt        = PT_W'(pt);
        r.ptthresh  = PTTH_W'(th);
        r.eta       = 8'h5A;
        r.nseg      = NSEG_W'(nseg);
        r.charge    = 1'b1;
        return r;
    endfunction

    function automatic pl2mtc_t mk_ln(input bit dv, input bit busy, input int ch,
                                      input int coin, input int th);
        pl2mtc_t l;
        l = '0;
        l.data_valid      = dv;
        l.busy            = busy;
        l.process_ch      = CH_W'(ch);
        l.common.cointype = COIN_W'(coin);
        l.common.ptthresh = PTTH_W'(th);
        l.common.eta      = 8'h33;
        l.common.phi      = 6'h15;
        return l;
    endfunction

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    mtc2sl_t o0, o1;

    initial begin
        cyc = 0;
        m_drop = 0;
        m_ovf = 0;
        for (int t = 0; t < N_THREADS; t++) begin m_v[t] = 0; m_ts[t] = 0; m_p[t] = '0; end
        idle();
        rst = 1'b1;
        ptcalc = '0;
        slcpipeline = '0;

        // Reset state
        do_reset();
        chk("reset mtc", 64'(mtc), 64'(0));

        // Result held 5 cycles then consumed; slot is then empty
        pt_s[1] = mk_pt(0, 100, 3, 1);
        step();
        idle();
        repeat (4) step();
        ln_s[0] = mk_ln(1, 1, 1, 0, 2);
        step();
        o0 = mtc2sl_t'(mtc[0]);
        chk("held valid", 64'(o0.valid), 64'(1));
        chk("held procflags", 64'(o0.procflags), 64'(4'h1));
        chk("held mdt_pt", 64'(o0.mdt_pt), 64'(100));
        step();
        o0 = mtc2sl_t'(mtc[0]);
        chk("reconsume procflags", 64'(o0.procflags), 64'(4'hE));

        // Unconsumed result times out
        do_reset();
        pt_s[0] = mk_pt(0, 50, 1, 0);
        step();
        idle();
        repeat (TIMEOUT) step();
        chk("timeout drop_cnt", 64'(drop_cnt), STATS ? 64'(1) : 64'(0));
        ln_s[0] = mk_ln(1, 1, 0, 0, 0);
        step();
        o0 = mtc2sl_t'(mtc[0]);
        chk("timeout procflags", 64'(o0.procflags), 64'(4'hE));

        // Two lanes on the same channel: lowest lane wins
        do_reset();
        pt_s[2] = mk_pt(0, 20, 5, 2);
        step();
        idle();
        ln_s[0] = mk_ln(1, 1, 2, 0, 4);
        ln_s[2] = mk_ln(1, 1, 2, 0, 4);
        step();
        o0 = mtc2sl_t'(mtc[0]);
        o1 = mtc2sl_t'(mtc[1]);
        chk("dup winner procflags", 64'(o0.procflags), 64'(4'h1));
        chk("dup loser procflags", 64'(o1.procflags), 64'(4'hE));

        // More valid lanes than outputs
        do_reset();
        for (int s = 0; s < N_SL; s++) ln_s[s] = mk_ln(1, 0, s, 0, s + 7);
        step();
        o0 = mtc2sl_t'(mtc[0]);
        o1 = mtc2sl_t'(mtc[1]);
        chk("ovf out0 ptthresh", 64'(o0.common.ptthresh), 64'(7));
        chk("ovf out1 ptthresh", 64'(o1.common.ptthresh), 64'(8));
        chk("ovf out0 procflags", 64'(o0.procflags), 64'(0));
        chk("ovf_cnt", 64'(ovf_cnt), STATS ? 64'(2) : 64'(0));

        // Same-cycle arrival bypassed, never stored
        do_reset();
        pt_s[2] = mk_pt(0, 0, 0, 3);
        ln_s[0] = mk_ln(1, 1, 2, 1, 0);
        step();
        o0 = mtc2sl_t'(mtc[0]);
        chk("bypass procflags", 64'(o0.procflags), 64'(4'h6));
        idle();
        ln_s[0] = mk_ln(1, 1, 2, 1, 0);
        step();
        o0 = mtc2sl_t'(mtc[0]);
        chk("bypass slot empty", 64'(o0.procflags), 64'(4'hE));
        chk("bypass drop_cnt", 64'(drop_cnt), 64'(0));

        // Reset discards held results without counting
        do_reset();
        for (int t = 0; t < N_THREADS; t++) pt_s[t] = mk_pt(0, 10 + t, 1, 1);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst mid-hold mtc", 64'(mtc), 64'(0));
        chk("rst mid-hold drop", 64'(drop_cnt), 64'(0));
        ln_s[0] = mk_ln(1, 1, 0, 0, 0);
        ln_s[1] = mk_ln(1, 1, 2, 0, 0);
        step();
        o0 = mtc2sl_t'(mtc[0]);
        o1 = mtc2sl_t'(mtc[1]);
        chk("after rst ch0", 64'(o0.procflags), 64'(4'hE));
        chk("after rst ch2", 64'(o1.procflags), 64'(4'hE));

        // Random traffic
        idle();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int t = 0; t < N_THREADS; t++) begin
                pt_s[t] = '0;
                if ($urandom_range(0, 9) < 3) begin
                    pt_s[t] = mk_pt(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                                    ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 511),
                                    $urandom_range(0, 15), $urandom_range(0, 3));
                    pt_s[t].eta    = 8'($urandom);
                    pt_s[t].charge = 1'($urandom);
                end
            end
            for (int s = 0; s < N_SL; s++) begin
                ln_s[s] = mk_ln($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
                                $urandom_range(0, 4),
                                ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7),
                                $urandom_range(0, 15));
                ln_s[s].common.eta = 8'($urandom);
                ln_s[s].common.phi = 6'($urandom);
            end
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mtc_builder_matched.md
MTC_BUILDER_MATCHED -- requirements
Module: mtc_builder_matched

Interface
REQ-001 SHALL have parameter N_THREADS, default 3, number of pT-calc threads.
REQ-002 SHALL have parameter N_SL, default 3, number of SL pipeline input lanes.
REQ-003 SHALL have parameter N_MTC, default 3, number of MTC outputs (1 <= N_MTC <= N_SL).
REQ-004 SHALL have parameter TIMEOUT, default 64, cycles a pT-calc result is held before discard (>= 2).
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  system clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 ptcalc  in  PTCALC2MTC_LEN x N_THREADS  per-thread pT result; the valid bit is the MSB.
REQ-009 slcpipeline  in  PL2MTC_LEN x N_SL  SL candidate; fields data_valid, busy, process_ch, common.
REQ-010 mtc  out  MTC2SL_LEN x N_MTC  MTC packet; MSB = valid.
REQ-011 drop_cnt  out  16  saturating count of pT results discarded (stats build only).
REQ-012 ovf_cnt  out  16  saturating count of valid SL candidates not given an output (stats build only).

Function
REQ-013 SHALL hold one result slot per thread: payload, valid flag, age counter of width clog2(TIMEOUT).
REQ-014 A valid ptcalc[t] SHALL be written into slot t on the next edge; age is cleared to 0.
REQ-015 Occupied, unconsumed slot t with age == TIMEOUT-1 SHALL be cleared; drop_cnt +1.
REQ-016 A new ptcalc[t] arriving into an occupied slot t that is not consumed in the same cycle SHALL overwrite it; drop_cnt +1.
REQ-017 Lane s with data_valid=1 and busy=1 SHALL consume slot process_ch; a same-cycle valid ptcalc[process_ch] SHALL be used by bypass and not stored.
REQ-018 When several lanes name the same process_ch in one cycle, only the lowest-index lane SHALL receive the result; the others are treated as a missing result.
REQ-019 A missing result (slot empty, no bypass) SHALL give an MTC with mdt fields zero and procflags 4'hE.
REQ-020 Procflags with a result: 3 if muid slid != 0; else 1 if pt != 0 and ptthresh >= SL ptthresh, 2 if pt != 0 and ptthresh < SL ptthresh; else with pt == 0: cointype == 0 gives 4 (nseg 0) or 5 (nseg 1), cointype != 0 gives 6 if nseg > 2, otherwise 4'hF.
REQ-021 busy=0 with data_valid=1 SHALL emit common fields with mdt fields and procflags zero, and SHALL not touch slots.
REQ-022 Valid lanes SHALL be packed onto outputs 0..N_MTC-1 in ascending lane order; lanes beyond N_MTC SHALL be dropped; ovf_cnt increases by the number dropped.
REQ-023 Outputs SHALL be registered with latency exactly 1 cycle from slcpipeline; unused outputs SHALL be all-zero; reserved field SHALL be 0.
REQ-024 process_ch >= N_THREADS SHALL be treated as a missing result.
REQ-025 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-026 While rst=1: all slots invalid, ages 0, mtc all zero, counters 0; inputs ignored.
REQ-027 Reset mid-hold SHALL discard held results without incrementing drop_cnt.

Configuration
REQ-028 With macro MTC_BUILDER_STATS_EN defined, drop_cnt/ovf_cnt SHALL be implemented as specified.
REQ-029 Without MTC_BUILDER_STATS_EN, drop_cnt/ovf_cnt SHALL be tied to 0 and no counter logic is generated; all other behaviour is identical.

Structure
REQ-030 Procflag code constants (PASS=1, FAIL=2, BOARD=3, NOSEG=4, ONESEG=5, PTFAIL=6, MISSING=E, UNKNOWN=F) and the slot struct SHALL live in the shared l0mdt package.
REQ-031 Packet formatting (REQ-019..021) SHALL be a combinational sub-module mtc_pkt_formatter, instantiated N_SL times.

Verification
REQ-032 ptcalc[1] valid pt=100, ptthresh=3 at cycle 0; lane 0 busy, ch=1, SL ptthresh=2 at cycle 5 -> mtc[0] valid, procflags=1 at cycle 6; slot 1 empty.
REQ-033 ptcalc[0] valid and never consumed, TIMEOUT=8 -> slot cleared after 8 cycles, drop_cnt=1; later lane ch=0 busy -> procflags=E.
REQ-034 Lanes 0 and 2 both ch=2 with slot full -> mtc[0] carries the result, mtc[1] has procflags=E.
REQ-035 N_SL=4, N_MTC=2, all four lanes valid -> lanes 0,1 output; ovf_cnt=2 (0 without the macro).
REQ-036 Same-cycle ptcalc[2] and lane ch=2 -> bypass used; slot 2 stays empty; drop_cnt unchanged.
REQ-037 rst asserted with 3 slots full -> next cycle all mtc zero, counters 0; a lane consuming any slot -> procflags=E.
